icache_axi_refill: RTL and testbench

Instruction-cache refill engine: accepts a line-fill (cached) or single-word (uncached) read request from the icache pipeline and issues one AXI4 read burst. It assembles the returned beats into a 256-bit line and hands it back with a one-cycle completion pulse, `rend_o`. It sits between the icache stage-1/stage-2 logic and the AXI read channels, and is the producer of the stage-1 refill inputs `s1_rend_i` and `s1_cacheline_rdata_i`.

---
 rtl/icache_axi_refill_pkg.sv | 20 ++
 rtl/icache_axi_refill.sv | 113 +++++++++++
 tb/tb_icache_axi_refill.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_axi_refill_pkg.sv
// Shared constants and types for the icache AXI refill engine.
// Holds the line geometry, the AXI encodings and the refill FSM state encoding.
package icache_axi_refill_pkg;

    localparam int BlockNum = 8;
    localparam int WordW    = 32;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    typedef logic [BlockNum*WordW-1:0] way_bus_t;

    typedef enum logic [1:0] {
        REFILL_IDLE = 2'd0,
        REFILL_AR   = 2'd1,
        REFILL_R    = 2'd2,
        REFILL_DONE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/icache_axi_refill.sv
// Instruction-cache refill engine: one AXI4 read burst per request,
// assembled into a full line and returned with a single-cycle rend_o pulse.
module icache_axi_refill
    import icache_axi_refill_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         BEATS  = BlockNum
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  cached_i,
    input  logic [31:0]           addr_i,
    output logic                  rend_o,
    output logic [BEATS*32-1:0]   cacheline_rdata_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic [3:0]            arid_o,
    output logic [31:0]           araddr_o,
    output logic [7:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [3:0]            rid_i,
    input  logic [31:0]           rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o
);

    localparam int          CNT_W    = $clog2(BEATS);
    localparam logic [31:0] LINE_MSK = 32'(BEATS*4 - 1);

    refill_state_e    state, state_nxt;
    logic             cached_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] widx;
    logic [31:0]      line [BEATS];
    logic             accept;
    logic             beat;

    // Only one read ID is ever outstanding, so the returned ID carries no information.
    logic unused_rid;
    assign unused_rid = ^rid_i;

    assign accept = (state == REFILL_IDLE) && req_i;
    assign beat   = (state == REFILL_R) && rvalid_i;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= REFILL_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            REFILL_IDLE: if (req_i)                state_nxt = REFILL_AR;
            REFILL_AR:   if (arready_i)            state_nxt = REFILL_R;
            REFILL_R:    if (rvalid_i && rlast_i)  state_nxt = REFILL_DONE;
            REFILL_DONE:                           state_nxt = REFILL_IDLE;
            default:                               state_nxt = REFILL_IDLE;
        endcase
    end

    assign arvalid_o = (state == REFILL_AR);
    assign rready_o  = (state == REFILL_R);
    assign rend_o    = (state == REFILL_DONE);
    assign busy_o    = (state != REFILL_IDLE);
    assign arid_o    = AXI_ID;
    assign arsize_o  = AXI_SIZE_4B;
    assign arburst_o = AXI_BURST_INCR;

    // Address fields are loaded once on accept, so they stay stable through AR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cached_q <= 1'b0;
            cnt      <= '0;
            err_o    <= 1'b0;
            araddr_o <= '0;
            arlen_o  <= '0;
        end else if (accept) begin
            cached_q <= cached_i;
            cnt      <= '0;
            err_o    <= 1'b0;
            araddr_o <= cached_i ? (addr_i & ~LINE_MSK) : addr_i;
            arlen_o  <= cached_i ? 8'(BEATS - 1) : 8'd0;
        end else if (beat) begin
            if (rresp_i != 2'b00)
                err_o <= 1'b1;
            if (cached_q && (cnt != CNT_W'(BEATS - 1)))
                cnt <= cnt + 1'b1;
        end
    end

    // Uncached words land at their natural slot so downstream bank select is unchanged.
    assign widx = cached_q ? cnt : araddr_o[CNT_W+1:2];

    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            for (int i = 0; i < BEATS; i++)
                line[i] <= '0;
        end else if (beat) begin
            line[widx] <= rdata_i;
        end
    end

    for (genvar g = 0; g < BEATS; g++) begin : g_flat
        assign cacheline_rdata_o[32*g +: 32] = line[g];
    end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed bench for icache_axi_refill: a cycle-stepped AXI slave drives each burst,
// expected lines are queued at request time and compared when rend_o fires.
module tb_icache_axi_refill;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req, cached;
    logic [31:0]  addr;
    logic         rend, err, busy;
    logic [255:0] line_o;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [255:0] line;
        logic         err;
        int           rend_cyc;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] last_line;
    logic         last_err;

    always #5 clk = ~clk;

    icache_axi_refill dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_i             (req),
        .cached_i          (cached),
        .addr_i            (addr),
        .rend_o            (rend),
        .cacheline_rdata_o (line_o),
        .err_o             (err),
        .busy_o            (busy),
        .arid_o            (arid),
        .araddr_o          (araddr),
        .arlen_o           (arlen),
        .arsize_o          (arsize),
        .arburst_o         (arburst),
        .arvalid_o         (arvalid),
        .arready_i         (arready),
        .rid_i             (rid),
        .rdata_i           (rdata),
        .rresp_i           (rresp),
        .rlast_i           (rlast),
        .rvalid_i          (rvalid),
        .rready_o          (rready)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_rready"},  rready,  0);
        check({tag, "_rend"},    rend,    0);
        check({tag, "_err"},     err,     0);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_araddr"},  araddr,  0);
        check({tag, "_arlen"},   arlen,   0);
        check({tag, "_line"},    line_o,  0);
    endtask

    // One request: cycle 0 is the IDLE cycle in which req is first presented.
    task automatic do_txn(input string tag, input logic [31:0] a, input logic cch,
                          input int ar_wait, input int gap_a, input int gap_b,
                          input int err_beat, input int abort_beat,
                          input bit toggle_req, input bit hold_req,
                          input logic [31:0] base);
        exp_t        e;
        exp_t        got;
        int          nb, cyc, bt, ar_seen, ngaps;
        bit          gap_pend, done, aborted;
        logic [31:0] exp_araddr;
        logic [7:0]  exp_arlen;

        nb     = cch ? 8 : 1;
        e.line = '0;
        for (int b = 0; b < nb; b++) begin
            if (cch) e.line[32*b +: 32] = base + 32'(b);
            else     e.line[32*a[4:2] +: 32] = base;
        end
        e.err      = (err_beat >= 0) && (err_beat < nb);
        ngaps      = cch ? (((gap_a > 0) && (gap_a < nb)) ? 1 : 0) + (((gap_b > 0) && (gap_b < nb)) ? 1 : 0) : 0;
        e.rend_cyc = (cch ? 10 : 3) + ar_wait + ngaps;
        exp_araddr = cch ? {a[31:5], 5'b0} : a;
        exp_arlen  = cch ? 8'd7 : 8'd0;
        if (abort_beat < 0) sb.push_back(e);

        @(posedge clk); #1;
        check({tag, "_c0_busy"}, busy, 0);
        check({tag, "_c0_rend"}, rend, 0);
        check({tag, "_c0_err_held"}, err, last_err);
        check({tag, "_c0_line_held"}, line_o, last_line);
        req = 1'b1; cached = cch; addr = a;

        cyc = 0; bt = 0; ar_seen = 0; gap_pend = 0; done = 0; aborted = 0;
        while (!done) begin
            @(posedge clk); #1;
            cyc++;
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'h0;
            if (cyc > 60) begin
                check({tag, "_rend_timeout"}, cyc, e.rend_cyc);
                req  = 1'b0;
                done = 1;
            end else if (rend) begin
                done = 1;
                if (sb.size() == 0) begin
                    check({tag, "_unexpected_rend"}, rend, 0);
                end else begin
                    got = sb.pop_front();
                    check({tag, "_rend_cycle"}, cyc, got.rend_cyc);
                    check({tag, "_line"}, line_o, got.line);
                    check({tag, "_err"}, err, got.err);
                    check({tag, "_busy_done"}, busy, 1);
                    last_line = got.line;
                    last_err  = got.err;
                end
                if (!hold_req) req = 1'b0;
            end else begin
                check({tag, "_busy"}, busy, 1);
                if (cyc == 1) begin
                    check({tag, "_c1_line_clr"}, line_o, 0);
                    check({tag, "_c1_err_clr"}, err, 0);
                    if (!hold_req && !toggle_req) req = 1'b0;
                end
                if (arvalid) begin
                    check({tag, "_araddr"}, araddr, exp_araddr);
                    check({tag, "_arlen"}, arlen, exp_arlen);
                    check({tag, "_arsize"}, arsize, 3'b010);
                    check({tag, "_arburst"}, arburst, 2'b01);
                    check({tag, "_arid"}, arid, 4'd0);
                    if (ar_seen >= ar_wait) arready = 1'b1;
                    ar_seen++;
                end
                if (rready) begin
                    if (toggle_req) req = ~req;
                    if (gap_pend) begin
                        gap_pend = 0;
                    end else begin
                        if (bt == abort_beat) begin
                            rst_n   = 1'b0;
                            aborted = 1;
                            done    = 1;
                        end
                        rvalid = 1'b1;
                        rdata  = cch ? base + 32'(bt) : base;
                        rresp  = (bt == err_beat) ? 2'b10 : 2'b00;
                        rlast  = (bt == nb - 1);
                        bt++;
                        if (bt == gap_a || bt == gap_b) gap_pend = 1;
                    end
                end
            end
        end

        if (aborted) begin
            @(posedge clk); #1;
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; req = 1'b0;
            check_reset_outputs({tag, "_abort"});
            rst_n     = 1'b1;
            last_line = '0;
            last_err  = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; cached = 1'b0; addr = '0;
        arready = 1'b0; rid = 4'h3; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        last_line = '0; last_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_arsize", arsize, 3'b010);
        check("reset_arburst", arburst, 2'b01);
        check("reset_arid", arid, 4'd0);
        rst_n = 1'b1;

        do_txn("cached",   32'h1FC0_0024, 1'b1, 0, 0, 0, -1, -1, 0, 0, 32'h0000_00A0);
        do_txn("uncached", 32'hBFC0_0014, 1'b0, 0, 0, 0, -1, -1, 0, 0, 32'hDEAD_BEEF);
        do_txn("backpr",   32'h8000_0048, 1'b1, 3, 2, 5, -1, -1, 0, 0, 32'h0000_0100);
        do_txn("errresp",  32'h0040_0000, 1'b1, 0, 0, 0,  4, -1, 0, 0, 32'h5555_0000);
        do_txn("err_clr",  32'h0040_0108, 1'b0, 1, 0, 0, -1, -1, 0, 0, 32'h0BAD_F00D);
        do_txn("toggle",   32'h1234_5660, 1'b1, 0, 0, 0, -1, -1, 1, 0, 32'hC000_0000);
        do_txn("hold1",    32'h2000_0000, 1'b1, 0, 0, 0, -1, -1, 0, 1, 32'h0000_1000);
        do_txn("hold2",    32'h2000_0020, 1'b1, 0, 0, 0, -1, -1, 0, 0, 32'h0000_2000);
        do_txn("abort",    32'h3000_0000, 1'b1, 0, 0, 0, -1,  3, 0, 0, 32'h7700_0000);
        do_txn("post_rst", 32'h0000_0008, 1'b0, 0, 0, 0, -1, -1, 0, 0, 32'h1234_5678);
        do_txn("post_rst2",32'h0000_0040, 1'b1, 0, 0, 0, -1, -1, 0, 0, 32'h0000_0E00);

        @(posedge clk); #1;
        check("final_rend", rend, 0);
        check("final_busy", busy, 0);
        check("final_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
